// File: rtl/riscv_mem_arb_pkg.sv
// riscv_mem_arb_pkg: shared constants and types for the imem/dmem arbiter.
// Optional build macro RISCV_MEM_ARB_RR_EN selects round-robin arbitration.

`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + 2 + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (1 + 2 + (d_))
`endif

package riscv_mem_arb_pkg;

   // Requester ids carried through the tag FIFO
   localparam logic REQ_IMEM = 1'b0;
   localparam logic REQ_DMEM = 1'b1;

   // Default message widths for a 32-bit address / 32-bit data memory
   localparam int ARB_REQ_W  = `VC_MEM_REQ_MSG_SZ(32, 32);
   localparam int ARB_RESP_W = `VC_MEM_RESP_MSG_SZ(32);

   // Grant lock: FREE re-arbitrates every cycle, LOCK freezes the grant
   typedef enum logic {
      ST_FREE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   // Fixed priority: the data port always wins when it is valid
   function automatic logic fixed_pick(input logic iv, input logic dv);
      return dv ? REQ_DMEM : (iv ? REQ_IMEM : REQ_DMEM);
   endfunction

   // Round-robin: on a conflict serve whoever was not served last
   function automatic logic rr_pick(input logic last, input logic iv, input logic dv);
      if (iv && dv) return ~last;
      return dv ? REQ_DMEM : REQ_IMEM;
   endfunction

endpackage

// File: rtl/riscv_mem_arb_tag_fifo.sv
// riscv_mem_arb_tag_fifo: DEPTH-entry, 1-bit FIFO holding the requester id
// of every request in flight, so in-order responses can be routed back.

module riscv_mem_arb_tag_fifo
#(
   parameter int DEPTH = 4
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic                         i_push_id,
   input  logic                         i_pop,
   output logic                         o_pop_id,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // Overflow/underflow protection: ignore push when full, pop when empty
   always_comb begin
      w_push   = i_push && !o_full;
      w_pop    = i_pop && !o_empty;
      o_full   = (r_count == FULL_CNT);
      o_empty  = (r_count == '0);
      o_pop_id = r_mem[r_rd_ptr];
      o_count  = r_count;
   end

   // Storage, pointers (wrap naturally, DEPTH is a power of two) and count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between the core's imem and dmem
// ports. Zero-latency request forwarding, in-order response routing via a tag
// FIFO. Define RISCV_MEM_ARB_RR_EN for round-robin; default is dmem priority.

module riscv_mem_arbiter
   import riscv_mem_arb_pkg::*;
#(
   parameter int REQ_W  = ARB_REQ_W,
   parameter int RESP_W = ARB_RESP_W,
   parameter int DEPTH  = 4
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [REQ_W-1:0]             imemreq_msg,
   input  logic                         imemreq_val,
   output logic                         imemreq_rdy,
   output logic [RESP_W-1:0]            imemresp_msg,
   output logic                         imemresp_val,
   input  logic [REQ_W-1:0]             dmemreq_msg,
   input  logic                         dmemreq_val,
   output logic                         dmemreq_rdy,
   output logic [RESP_W-1:0]            dmemresp_msg,
   output logic                         dmemresp_val,
   output logic [REQ_W-1:0]             memreq_msg,
   output logic                         memreq_val,
   input  logic                         memreq_rdy,
   input  logic [RESP_W-1:0]            memresp_msg,
   input  logic                         memresp_val,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding,
   output logic                         resp_err
);

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   logic       r_lock_id;
   logic       w_lock_id_nxt;
   logic       w_free_gnt;
   logic       w_gnt;
   logic       w_gnt_val;
   logic       w_req_val;
   logic       w_accept;
   logic       w_pop;
   logic       w_pop_id;
   logic       w_full;
   logic       w_empty;

`ifdef RISCV_MEM_ARB_RR_EN
   logic       r_last;

   // Last-served requester; resets to dmem so imem gets first turn
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_last <= REQ_DMEM;
      else if (w_accept)
         r_last <= w_gnt;
   end

   // Free-running grant when no lock is held
   always_comb w_free_gnt = rr_pick(r_last, imemreq_val, dmemreq_val);
`else
   // Free-running grant when no lock is held
   always_comb w_free_gnt = fixed_pick(imemreq_val, dmemreq_val);
`endif

   // Grant mux, handshakes and response routing. Internal accept/pop are
   // ungated; the port-level val/rdy are forced low while reset is held.
   always_comb begin
      w_gnt        = (r_state == ST_LOCK) ? r_lock_id : w_free_gnt;
      w_gnt_val    = (w_gnt == REQ_DMEM) ? dmemreq_val : imemreq_val;
      w_req_val    = w_gnt_val && !w_full;
      w_accept     = w_req_val && memreq_rdy;
      memreq_val   = reset && w_req_val;
      memreq_msg   = (w_gnt == REQ_DMEM) ? dmemreq_msg : imemreq_msg;
      imemreq_rdy  = reset && (w_gnt == REQ_IMEM) && memreq_rdy && !w_full;
      dmemreq_rdy  = reset && (w_gnt == REQ_DMEM) && memreq_rdy && !w_full;
      w_pop        = memresp_val && !w_empty;
      imemresp_val = reset && w_pop && (w_pop_id == REQ_IMEM);
      dmemresp_val = reset && w_pop && (w_pop_id == REQ_DMEM);
      imemresp_msg = memresp_msg;
      dmemresp_msg = memresp_msg;
   end

   // Lock state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_FREE;
         r_lock_id <= REQ_IMEM;
      end else begin
         r_state   <= w_state_nxt;
         r_lock_id <= w_lock_id_nxt;
      end
   end

   // Lock next-state: a stalled offer freezes the grant until accepted or
   // until the locked requester withdraws
   always_comb begin
      w_state_nxt   = r_state;
      w_lock_id_nxt = r_lock_id;
      case (r_state)
         ST_FREE: begin
            if (w_req_val && !memreq_rdy) begin
               w_state_nxt   = ST_LOCK;
               w_lock_id_nxt = w_gnt;
            end
         end
         ST_LOCK: begin
            if (w_accept || !w_gnt_val)
               w_state_nxt = ST_FREE;
         end
         default: w_state_nxt = ST_FREE;
      endcase
   end

   // Sticky flag: a response showed up with nothing outstanding
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         resp_err <= 1'b0;
      else if (memresp_val && w_empty)
         resp_err <= 1'b1;
   end

   riscv_mem_arb_tag_fifo #(
      .DEPTH     (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_accept),
      .i_push_id (w_gnt),
      .i_pop     (w_pop),
      .o_pop_id  (w_pop_id),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (outstanding)
   );

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed stimulus with a response scoreboard.
`timescale 1ns/1ps

module tb_riscv_mem_arbiter;
   import riscv_mem_arb_pkg::*;

   localparam int REQ_W  = 67;
   localparam int RESP_W = 35;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [REQ_W-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
   logic              imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
   logic [RESP_W-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
   logic              imemresp_val, dmemresp_val;
   logic              memreq_val, memreq_rdy, memresp_val;
   logic [CNT_W-1:0]  outstanding;
   logic              resp_err;

   typedef struct {
      logic              id;
      logic [RESP_W-1:0] msg;
   } sb_t;

   sb_t  sb_q[$];
   int   n_tot = 0;
   int   n_bad = 0;
   logic m_last = 1'b1;

   always #5 clk = ~clk;

   riscv_mem_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
      .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val),
      .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
      .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val),
      .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
      .memresp_msg(memresp_msg), .memresp_val(memresp_val),
      .outstanding(outstanding), .resp_err(resp_err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [REQ_W-1:0] mk_req(input logic [31:0] a);
      return {1'b0, a, 2'b00, 32'hA5A5_0000 ^ a};
   endfunction

   function automatic logic [RESP_W-1:0] mk_resp(input logic [31:0] a);
      return {3'b101, a};
   endfunction

   // Expected winner of a free arbitration
   function automatic logic model_pick(input logic iv, input logic dv);
`ifdef RISCV_MEM_ARB_RR_EN
      if (iv && dv) return ~m_last;
`endif
      return dv;
   endfunction

   // Drive one cycle's inputs just after the falling edge, then settle
   task automatic drive(input logic iv, input logic [31:0] ia,
                        input logic dv, input logic [31:0] da,
                        input logic mrdy, input logic rv, input logic [RESP_W-1:0] rm);
      @(negedge clk);
      imemreq_val = iv; imemreq_msg = mk_req(ia);
      dmemreq_val = dv; dmemreq_msg = mk_req(da);
      memreq_rdy  = mrdy;
      memresp_val = rv; memresp_msg = rm;
      #1;
   endtask

   task automatic expect_push(input logic id, input logic [31:0] a);
      sb_t e;
      e.id = id; e.msg = mk_resp(a);
      sb_q.push_back(e);
      m_last = id;
   endtask

   // Memory returns the oldest outstanding response; check its routing
   task automatic resp_pop(input string tag);
      sb_t e;
      chk({tag, "_sb"}, 128'(sb_q.size() != 0), 1);
      if (sb_q.size() == 0) return;
      e = sb_q[0];
      drive(0, 0, 0, 0, 0, 1, e.msg);
      chk({tag, "_outst"}, 128'(outstanding), 128'(sb_q.size()));
      chk({tag, "_ival"}, 128'(imemresp_val), 128'(e.id == REQ_IMEM));
      chk({tag, "_dval"}, 128'(dmemresp_val), 128'(e.id == REQ_DMEM));
      chk({tag, "_msg"}, 128'((e.id == REQ_IMEM) ? imemresp_msg : dmemresp_msg), 128'(e.msg));
      void'(sb_q.pop_front());
   endtask

   initial begin
      logic w;

      // Reset held with every input active
      reset = 1'b0;
      imemreq_val = 1; dmemreq_val = 1; memreq_rdy = 1; memresp_val = 1;
      imemreq_msg = mk_req(32'h10); dmemreq_msg = mk_req(32'h20); memresp_msg = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_irdy", 128'(imemreq_rdy), 0);
      chk("rst_drdy", 128'(dmemreq_rdy), 0);
      chk("rst_mval", 128'(memreq_val), 0);
      chk("rst_iresp", 128'(imemresp_val), 0);
      chk("rst_dresp", 128'(dmemresp_val), 0);
      chk("rst_outst", 128'(outstanding), 0);
      chk("rst_err", 128'(resp_err), 0);
      @(negedge clk);
      imemreq_val = 0; dmemreq_val = 0; memreq_rdy = 0; memresp_val = 0;
      reset = 1'b1;

      // Conflict: both valid, memory always ready
      for (int k = 0; k < 3; k++) begin
         w = model_pick(1, 1);
         drive(1, 32'h100 + 4*k, 1, 32'h200 + 4*k, 1, 0, '0);
         chk("conf_irdy", 128'(imemreq_rdy), 128'(w == REQ_IMEM));
         chk("conf_drdy", 128'(dmemreq_rdy), 128'(w == REQ_DMEM));
         chk("conf_msg", 128'(memreq_msg), 128'(w ? mk_req(32'h200 + 4*k) : mk_req(32'h100 + 4*k)));
         expect_push(w, w ? 32'h200 + 4*k : 32'h100 + 4*k);
      end
      repeat (3) resp_pop("conf_resp");

      // Lock hold on dmem while memory stalls
      for (int k = 0; k < 3; k++) begin
         drive(1, 32'h180, 1, 32'h280, 0, 0, '0);
         chk("lockd_msg", 128'(memreq_msg), 128'(mk_req(32'h280)));
         chk("lockd_mval", 128'(memreq_val), 1);
         chk("lockd_drdy", 128'(dmemreq_rdy), 0);
      end
      drive(1, 32'h180, 1, 32'h280, 1, 0, '0);
      chk("lockd_drdy4", 128'(dmemreq_rdy), 1);
      chk("lockd_irdy4", 128'(imemreq_rdy), 0);
      expect_push(REQ_DMEM, 32'h280);

      // Lock on imem holds even when dmem later raises val
      drive(1, 32'h190, 0, 0, 0, 0, '0);
      chk("locki_msg0", 128'(memreq_msg), 128'(mk_req(32'h190)));
      for (int k = 0; k < 2; k++) begin
         drive(1, 32'h190, 1, 32'h290, 0, 0, '0);
         chk("locki_msg", 128'(memreq_msg), 128'(mk_req(32'h190)));
      end
      drive(1, 32'h190, 1, 32'h290, 1, 0, '0);
      chk("locki_irdy", 128'(imemreq_rdy), 1);
      chk("locki_drdy", 128'(dmemreq_rdy), 0);
      expect_push(REQ_IMEM, 32'h190);

      // Locked requester withdraws: val drops that cycle, lock released
      drive(1, 32'h1a0, 0, 0, 0, 0, '0);
      drive(0, 0, 1, 32'h2a0, 0, 0, '0);
      chk("drop_mval", 128'(memreq_val), 0);
      drive(0, 0, 1, 32'h2a0, 1, 0, '0);
      chk("drop_drdy", 128'(dmemreq_rdy), 1);
      chk("drop_msg", 128'(memreq_msg), 128'(mk_req(32'h2a0)));
      expect_push(REQ_DMEM, 32'h2a0);
      repeat (3) resp_pop("lock_resp");

      // Full: four imem requests with no responses
      for (int k = 0; k < 4; k++) begin
         drive(1, 32'h400 + 4*k, 0, 0, 1, 0, '0);
         chk("full_irdy", 128'(imemreq_rdy), 1);
         expect_push(REQ_IMEM, 32'h400 + 4*k);
      end
      drive(1, 32'h410, 0, 0, 1, 0, '0);
      chk("full_outst4", 128'(outstanding), 4);
      chk("full_irdy0", 128'(imemreq_rdy), 0);
      chk("full_mval0", 128'(memreq_val), 0);
      drive(1, 32'h410, 0, 0, 1, 1, sb_q[0].msg);
      chk("full_pop_irdy", 128'(imemreq_rdy), 0);
      chk("full_pop_ival", 128'(imemresp_val), 1);
      chk("full_pop_outst", 128'(outstanding), 4);
      void'(sb_q.pop_front());
      drive(1, 32'h410, 0, 0, 1, 0, '0);
      chk("full_outst3", 128'(outstanding), 3);
      chk("full_irdy1", 128'(imemreq_rdy), 1);
      expect_push(REQ_IMEM, 32'h410);
      repeat (4) resp_pop("full_resp");

      // Routing, with one accept overlapping a response
      drive(1, 32'h100, 0, 0, 1, 0, '0);
      chk("rt_irdy0", 128'(imemreq_rdy), 1);
      expect_push(REQ_IMEM, 32'h100);
      drive(0, 0, 1, 32'h200, 1, 0, '0);
      chk("rt_drdy", 128'(dmemreq_rdy), 1);
      expect_push(REQ_DMEM, 32'h200);
      drive(1, 32'h104, 0, 0, 1, 1, sb_q[0].msg);
      chk("rt_irdy1", 128'(imemreq_rdy), 1);
      chk("rt_ival", 128'(imemresp_val), 1);
      chk("rt_dval", 128'(dmemresp_val), 0);
      chk("rt_outst", 128'(outstanding), 2);
      void'(sb_q.pop_front());
      expect_push(REQ_IMEM, 32'h104);
      repeat (2) resp_pop("rt_resp");
      drive(0, 0, 0, 0, 0, 0, '0);
      chk("rt_outst0", 128'(outstanding), 0);

      // Spurious response with nothing outstanding
      drive(0, 0, 0, 0, 0, 1, mk_resp(32'hdead));
      chk("sp_ival", 128'(imemresp_val), 0);
      chk("sp_dval", 128'(dmemresp_val), 0);
      chk("sp_err_pre", 128'(resp_err), 0);
      drive(0, 0, 0, 0, 0, 0, '0);
      chk("sp_err", 128'(resp_err), 1);
      repeat (3) drive(1, 32'h500, 0, 0, 0, 0, '0);
      chk("sp_err_sticky", 128'(resp_err), 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("sp_err_rst", 128'(resp_err), 0);
      chk("sp_mval_rst", 128'(memreq_val), 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-to-one memory-port arbiter that lets the 5-stage RISCV core's instruction and data memory ports share one unified memory port. It sits between the core's imemreq/imemresp and dmemreq/dmemresp interfaces and a single memory (or cache) port. Requests are forwarded with zero latency under val/rdy handshakes. An in-order tag FIFO routes each response back to the requester that issued it.

## Interface
Parameters:
- REQ_W, default 67: request message width, equal to VC_MEM_REQ_MSG_SZ(32,32).
- RESP_W, default 35: response message width, equal to VC_MEM_RESP_MSG_SZ(32).
- DEPTH, default 4: maximum outstanding requests; a power of two, at least 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - reset  in  1  asynchronous, active-low reset.
- Instruction requester (requester 0):
  - imemreq_msg  in  REQ_W  request.
  - imemreq_val  in  1  request valid.
  - imemreq_rdy  out  1  request accepted.
  - imemresp_msg  out  RESP_W  response.
  - imemresp_val  out  1  response valid.
- Data requester (requester 1):
  - dmemreq_msg  in  REQ_W  request.
  - dmemreq_val  in  1  request valid.
  - dmemreq_rdy  out  1  request accepted.
  - dmemresp_msg  out  RESP_W  response.
  - dmemresp_val  out  1  response valid.
- Shared memory port:
  - memreq_msg  out  REQ_W  request.
  - memreq_val  out  1  request valid.
  - memreq_rdy  in  1  memory ready.
  - memresp_msg  in  RESP_W  response.
  - memresp_val  in  1  response valid.
- Status:
  - outstanding  out  $clog2(DEPTH+1)  count of in-flight requests.
  - resp_err  out  1  sticky: a response arrived with no request outstanding.

## Operation
- Memory port contract:
  - The memory returns responses strictly in request order.
  - Response channels have no back-pressure; the requesters always sink responses.
- Accept condition: a request is accepted on a cycle with memreq_val && memreq_rdy.
  - On accept, push the winner's id (0 = imem, 1 = dmem) into the tag FIFO.
- Arbitration, evaluated only when no lock is held:
  - Default policy is fixed priority: dmem wins over imem. The M stage stalls the whole pipeline, so the data port must not be starved.
  - A requester with val low never wins.
- Lock:
  - Set when memreq_val=1 && memreq_rdy=0.
  - While set, the grant is frozen to the locked requester, and memreq_msg and memreq_val stay stable.
  - Cleared on accept.
  - If the locked requester drops val, the lock clears and memreq_val falls that cycle.
- Full behaviour: when the FIFO is full (outstanding == DEPTH):
  - memreq_val = 0 and both req_rdy = 0.
  - A same-cycle memresp_val does not reopen acceptance; there is no combinational resp-to-rdy path.
- Output equations:
  - memreq_val = (granted requester's val) && !full.
  - imemreq_rdy / dmemreq_rdy = granted && memreq_rdy && !full.
  - memreq_msg = granted requester's msg.
- Response routing:
  - On memresp_val with a non-empty FIFO: pop the FIFO, drive memresp_msg to both resp_msg outputs, and assert only the resp_val selected by the popped id.
  - On memresp_val with an empty FIFO: drop the response (both resp_val = 0) and set resp_err. resp_err clears only on reset.
- Simultaneous push and pop when not full: outstanding is unchanged and the FIFO order is preserved.
- Reset values (asynchronous, while reset=0):
  - outstanding = 0, resp_err = 0, lock = 0, FIFO empty, round-robin pointer = 1.
  - All val/rdy outputs are forced to 0.
  - Message outputs are don't-care.
- Reset deasserted mid-transaction: in-flight responses that arrive afterwards are dropped and flagged via resp_err.

## Timing
- Request path: combinational, 0 cycles from reqval to memreq_val. rdy is combinational from memreq_rdy and val.
- Response path: combinational, 0 cycles from memresp_val to imemresp_val/dmemresp_val.
- The FIFO pointers, count, lock, round-robin pointer and resp_err update on the rising edge of clk.
- Throughput: one request accepted per cycle.
  - Round-robin build: back-to-back accepts alternate requesters when both are valid.
  - Fixed-priority build: dmem is accepted back-to-back while its val stays high.

## Configuration
- RISCV_MEM_ARB_RR_EN:
  - Defined: round-robin arbitration.
    - The winner is the requester not served on the last accept.
    - The pointer records the last-served id; its reset value of 1 gives imem first priority.
    - The pointer updates only on accept.
  - Undefined: fixed dmem priority; the pointer register is not built.
- Lock and full behaviour are identical in both builds.

## Structure
- Shared package riscv_mem_arb_pkg holds:
  - The requester-id constants REQ_IMEM=1'b0 and REQ_DMEM=1'b1.
  - Default message widths derived from the VC_MEM_REQ_MSG_SZ and VC_MEM_RESP_MSG_SZ macros.
- One sub-module, riscv_mem_arb_tag_fifo:
  - DEPTH-entry, 1-bit-wide FIFO with push/pop/full/empty/count.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Test plan
- Reset: hold reset=0 with all inputs valid → every val/rdy output is 0, outstanding=0, resp_err=0.
- Conflict: imem and dmem both valid, memreq_rdy=1.
  - Fixed build: dmem is accepted 3 cycles in a row and imemreq_rdy=0 throughout.
  - Round-robin build: accepts go imem, dmem, imem.
- Lock hold: dmem wins with memreq_rdy=0 for 3 cycles while imem is also valid → memreq_msg equals the dmem msg for all 3 cycles; dmemreq_rdy pulses in cycle 4 once memreq_rdy=1.
- Full: issue 4 imem requests with no responses → outstanding=4 and imemreq_rdy=0. Then assert memresp_val with a new request pending → no accept that cycle; accepted next cycle; outstanding goes 4→3→4.
- Routing: accept imem(addr 0x100), dmem(addr 0x200), imem(addr 0x104), then return 3 responses → imemresp_val, dmemresp_val, imemresp_val in that order, and outstanding returns to 0.
- Spurious response: assert memresp_val with outstanding=0 → no resp_val asserted; resp_err=1 and stays 1 until reset.
